// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

   localparam int BLOCK_BITS = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEM_REQ = 2'd1,
      RESP    = 2'd2
   } state_t;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone requester always wins, and on a tie
// the side that was not granted last time goes next.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic   req_icache,
   input  logic   req_dcache,
   input  grant_t last_grant,
   output grant_t winner,
   output logic   valid
);

   // Pick the winner purely from the current requests and grant history
   always_comb begin
      winner = ICACHE;
      valid  = req_icache | req_dcache;
      if (req_icache && req_dcache) begin
         winner = (last_grant == ICACHE) ? DCACHE : ICACHE;
      end else if (req_dcache) begin
         winner = DCACHE;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the icache and dcache: grants
// one requester, holds the strobes until the memory answers (or the timeout
// expires), and hands the block back with a one-cycle ready pulse.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [31:0]           i_address,
   output logic [BLOCK_BITS-1:0] i_block_data,
   output logic                  i_ready,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [31:0]           d_address,
   input  logic [63:0]           d_write_data,
   output logic [BLOCK_BITS-1:0] d_block_data,
   output logic                  d_ready,
   output logic [31:0]           mem_address,
   output logic [63:0]           mem_write_data,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   input  logic [BLOCK_BITS-1:0] mem_block_read_data,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic                  timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] BLOCK_MASK = 32'hFFFF_FFF0;

   state_t                  state;
   grant_t                  last_grant;
   grant_t                  granted;
   grant_t                  winner;
   logic                    arb_valid;
   logic [CNT_W-1:0]        count;
   logic [BLOCK_BITS-1:0]   block_reg;

   rr_arbiter2 u_rr (
      .req_icache (i_req),
      .req_dcache (d_read | d_write),
      .last_grant (last_grant),
      .winner     (winner),
      .valid      (arb_valid)
   );

   // Both caches see the same captured block; each only looks at it while
   // its own ready pulse is high.
   assign i_block_data = block_reg;
   assign d_block_data = block_reg;

   // Transaction sequencer: grant in IDLE, wait on memory or the timeout in
   // MEM_REQ, then a single RESP cycle that pulses the granted side's ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         last_grant     <= ICACHE;
         granted        <= ICACHE;
         count          <= '0;
         block_reg      <= '0;
         i_ready        <= 1'b0;
         d_ready        <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         busy           <= 1'b0;
         timeout        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  state      <= MEM_REQ;
                  busy       <= 1'b1;
                  granted    <= winner;
                  last_grant <= winner;
                  count      <= '0;
                  if (winner == DCACHE && d_write) begin
                     mem_write_out  <= 1'b1;
                     mem_address    <= d_address;
                     mem_write_data <= d_write_data;
                  end else begin
                     mem_read_out   <= 1'b1;
                     mem_write_data <= '0;
                     mem_address    <= ((winner == DCACHE) ? d_address : i_address) & BLOCK_MASK;
                  end
               end
            end
            MEM_REQ: begin
               if (mem_ready || count == CNT_LAST) begin
                  state         <= RESP;
                  mem_read_out  <= 1'b0;
                  mem_write_out <= 1'b0;
                  i_ready       <= (granted == ICACHE);
                  d_ready       <= (granted == DCACHE);
                  if (mem_ready) begin
                     block_reg <= mem_block_read_data;
                  end else begin
                     block_reg <= '0;
                     timeout   <= 1'b1;
                  end
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            RESP: begin
               state   <= IDLE;
               busy    <= 1'b0;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout so the abort path is
// reachable in a few cycles.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic                  clk;
   logic                  reset;
   logic                  i_req;
   logic [31:0]           i_address;
   logic [BLOCK_BITS-1:0] i_block_data;
   logic                  i_ready;
   logic                  d_read;
   logic                  d_write;
   logic [31:0]           d_address;
   logic [63:0]           d_write_data;
   logic [BLOCK_BITS-1:0] d_block_data;
   logic                  d_ready;
   logic [31:0]           mem_address;
   logic [63:0]           mem_write_data;
   logic                  mem_read_out;
   logic                  mem_write_out;
   logic [BLOCK_BITS-1:0] mem_block_read_data;
   logic                  mem_ready;
   logic                  busy;
   logic                  timeout;

   int tests_run;
   int tests_failed;

   localparam logic [127:0] BLK_A5 = {16{8'hA5}};
   localparam logic [127:0] BLK_11 = {16{8'h11}};
   localparam logic [127:0] BLK_22 = {16{8'h22}};
   localparam logic [127:0] BLK_33 = {16{8'h33}};
   localparam logic [127:0] BLK_FF = {16{8'hFF}};

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk                 (clk),
      .reset               (reset),
      .i_req               (i_req),
      .i_address           (i_address),
      .i_block_data        (i_block_data),
      .i_ready             (i_ready),
      .d_read              (d_read),
      .d_write             (d_write),
      .d_address           (d_address),
      .d_write_data        (d_write_data),
      .d_block_data        (d_block_data),
      .d_ready             (d_ready),
      .mem_address         (mem_address),
      .mem_write_data      (mem_write_data),
      .mem_read_out        (mem_read_out),
      .mem_write_out       (mem_write_out),
      .mem_block_read_data (mem_block_read_data),
      .mem_ready           (mem_ready),
      .busy                (busy),
      .timeout             (timeout)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dread,
                                input logic dwrite, input logic [31:0] daddr, input logic [63:0] wdata);
      i_req        = ireq;
      i_address    = iaddr;
      d_read       = dread;
      d_write      = dwrite;
      d_address    = daddr;
      d_write_data = wdata;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " i_ready"},        128'(i_ready), 128'd0);
      checkOutput({tag, " d_ready"},        128'(d_ready), 128'd0);
      checkOutput({tag, " mem_read_out"},   128'(mem_read_out), 128'd0);
      checkOutput({tag, " mem_write_out"},  128'(mem_write_out), 128'd0);
      checkOutput({tag, " mem_address"},    128'(mem_address), 128'd0);
      checkOutput({tag, " mem_write_data"}, 128'(mem_write_data), 128'd0);
      checkOutput({tag, " i_block_data"},   i_block_data, 128'd0);
      checkOutput({tag, " d_block_data"},   d_block_data, 128'd0);
      checkOutput({tag, " busy"},           128'(busy), 128'd0);
      checkOutput({tag, " timeout"},        128'(timeout), 128'd0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      mem_ready    = 1'b0;
      mem_block_read_data = '0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0);
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      reset = 1'b0;

      // mem_ready in IDLE must not start anything
      mem_ready = 1'b1;
      mem_block_read_data = BLK_FF;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready busy", 128'(busy), 128'd0);
      checkOutput("idle_ready i_ready", 128'(i_ready), 128'd0);
      checkOutput("idle_ready d_ready", 128'(d_ready), 128'd0);

      // Single icache read, memory answers two cycles into MEM_REQ
      applyStimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 64'h0);
      @(negedge clk);
      checkOutput("ird read_out", 128'(mem_read_out), 128'd1);
      checkOutput("ird write_out", 128'(mem_write_out), 128'd0);
      checkOutput("ird address", 128'(mem_address), 128'h0000_1230);
      checkOutput("ird busy", 128'(busy), 128'd1);
      @(negedge clk);
      checkOutput("ird read_held", 128'(mem_read_out), 128'd1);
      mem_ready = 1'b1;
      mem_block_read_data = BLK_A5;
      @(negedge clk);
      checkOutput("ird i_ready", 128'(i_ready), 128'd1);
      checkOutput("ird block", i_block_data, BLK_A5);
      checkOutput("ird d_ready", 128'(d_ready), 128'd0);
      checkOutput("ird strobe_low", 128'(mem_read_out), 128'd0);
      mem_ready = 1'b0;
      i_req = 1'b0;
      @(negedge clk);
      checkOutput("ird i_ready_end", 128'(i_ready), 128'd0);
      checkOutput("ird busy_end", 128'(busy), 128'd0);

      // dcache write-through
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0048, 64'hDEAD_BEEF_0000_0001);
      @(negedge clk);
      checkOutput("dwr write_out", 128'(mem_write_out), 128'd1);
      checkOutput("dwr read_out", 128'(mem_read_out), 128'd0);
      checkOutput("dwr address", 128'(mem_address), 128'h0000_0048);
      checkOutput("dwr data", 128'(mem_write_data), 128'hDEAD_BEEF_0000_0001);
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("dwr d_ready", 128'(d_ready), 128'd1);
      checkOutput("dwr i_ready", 128'(i_ready), 128'd0);
      checkOutput("dwr strobe_low", 128'(mem_write_out), 128'd0);
      mem_ready = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0);
      @(negedge clk);
      checkOutput("dwr d_ready_end", 128'(d_ready), 128'd0);

      // dcache read (leaves last_grant at DCACHE), then reset mid-MEM_REQ
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 64'h0);
      @(negedge clk);
      checkOutput("rst pre read_out", 128'(mem_read_out), 128'd1);
      #2 reset = 1'b1;
      #1;
      checkAllZero("rst async");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0);
      @(negedge clk);
      reset = 1'b0;

      // Tie after reset: dcache first, icache right after RESP
      applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_3008, 64'h0);
      @(negedge clk);
      checkOutput("tie1 address", 128'(mem_address), 128'h0000_3000);
      checkOutput("tie1 read_out", 128'(mem_read_out), 128'd1);
      mem_ready = 1'b1;
      mem_block_read_data = BLK_11;
      @(negedge clk);
      checkOutput("tie1 d_ready", 128'(d_ready), 128'd1);
      checkOutput("tie1 block", d_block_data, BLK_11);
      checkOutput("tie1 i_ready", 128'(i_ready), 128'd0);
      mem_ready = 1'b0;
      d_read = 1'b0;
      @(negedge clk);
      checkOutput("tie1 idle busy", 128'(busy), 128'd0);
      @(negedge clk);
      checkOutput("tie2 address", 128'(mem_address), 128'h0000_2000);
      checkOutput("tie2 read_out", 128'(mem_read_out), 128'd1);
      mem_ready = 1'b1;
      mem_block_read_data = BLK_22;
      @(negedge clk);
      checkOutput("tie2 i_ready", 128'(i_ready), 128'd1);
      checkOutput("tie2 block", i_block_data, BLK_22);
      checkOutput("tie2 d_ready", 128'(d_ready), 128'd0);
      mem_ready = 1'b0;
      i_req = 1'b0;
      @(negedge clk);

      // Next tie goes to the dcache again; read+write counts as a write
      applyStimulus(1'b1, 32'h0000_2004, 1'b1, 1'b1, 32'h0000_0044, 64'h0123_4567_89AB_CDEF);
      @(negedge clk);
      checkOutput("tie3 write_out", 128'(mem_write_out), 128'd1);
      checkOutput("tie3 read_out", 128'(mem_read_out), 128'd0);
      checkOutput("tie3 address", 128'(mem_address), 128'h0000_0044);
      checkOutput("tie3 data", 128'(mem_write_data), 128'h0123_4567_89AB_CDEF);
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("tie3 d_ready", 128'(d_ready), 128'd1);
      mem_ready = 1'b0;
      d_read = 1'b0;
      d_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("tie4 address", 128'(mem_address), 128'h0000_2000);
      checkOutput("tie4 read_out", 128'(mem_read_out), 128'd1);
      mem_ready = 1'b1;
      mem_block_read_data = BLK_33;
      @(negedge clk);
      checkOutput("tie4 i_ready", 128'(i_ready), 128'd1);
      checkOutput("tie4 block", i_block_data, BLK_33);
      mem_ready = 1'b0;
      i_req = 1'b0;
      @(negedge clk);
      checkOutput("pre_to timeout", 128'(timeout), 128'd0);

      // Timeout: eight MEM_REQ cycles, then release with zero data
      mem_block_read_data = BLK_FF;
      applyStimulus(1'b1, 32'h0000_5678, 1'b0, 1'b0, 32'h0, 64'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput($sformatf("to strobe%0d", k), 128'(mem_read_out), 128'd1);
      end
      @(negedge clk);
      checkOutput("to strobe_low", 128'(mem_read_out), 128'd0);
      checkOutput("to i_ready", 128'(i_ready), 128'd1);
      checkOutput("to block", i_block_data, 128'd0);
      checkOutput("to flag", 128'(timeout), 128'd1);
      i_req = 1'b0;
      @(negedge clk);
      checkOutput("to busy_end", 128'(busy), 128'd0);
      checkOutput("to flag_sticky", 128'(timeout), 128'd1);

      // Normal transaction after the timeout
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_008C, 64'h0);
      @(negedge clk);
      checkOutput("post address", 128'(mem_address), 128'h0000_0080);
      mem_ready = 1'b1;
      mem_block_read_data = BLK_A5;
      @(negedge clk);
      checkOutput("post d_ready", 128'(d_ready), 128'd1);
      checkOutput("post block", d_block_data, BLK_A5);
      checkOutput("post flag", 128'(timeout), 128'd1);
      mem_ready = 1'b0;
      d_read = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single main-memory port shared by the instruction cache and the data cache. It accepts block-read misses from the instruction cache and block-read misses or write-through writes from the data cache. It grants the memory port to one requester at a time and holds the memory strobes until `mem_ready`. It captures the 128-bit block and returns it to the granted cache with a one-cycle ready pulse, and it bounds every memory transaction with a timeout.

## Interface

- `TIMEOUT_CYCLES`, default 256: maximum cycles in MEM_REQ without `mem_ready` before the transaction is aborted; must be at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  icache block-read request; level, held until `i_ready`.
- `i_address`  in  32  icache miss address.
- `i_block_data`  out  128  block returned to icache; valid while `i_ready`=1.
- `i_ready`  out  1  one-cycle completion pulse to icache.
- `d_read`  in  1  dcache block-read request; level, held until `d_ready`.
- `d_write`  in  1  dcache write-through request; level, held until `d_ready`.
- `d_address`  in  32  dcache address.
- `d_write_data`  in  64  dcache write data.
- `d_block_data`  out  128  block returned to dcache; valid while `d_ready`=1.
- `d_ready`  out  1  one-cycle completion pulse to dcache.
- `mem_address`  out  32  address to main memory.
- `mem_write_data`  out  64  write data to main memory.
- `mem_read_out`  out  1  memory read strobe; level.
- `mem_write_out`  out  1  memory write strobe; level.
- `mem_block_read_data`  in  128  block from memory; sampled when `mem_ready`=1.
- `mem_ready`  in  1  memory completion.
- `busy`  out  1  high in every state except IDLE.
- `timeout`  out  1  sticky error flag; cleared only by reset.

## Operation

- States:
  - IDLE: no transaction in progress.
  - MEM_REQ: memory strobes asserted; waits for `mem_ready`.
  - RESP: one cycle; drives the ready pulse to the granted requester.
- IDLE transitions:
  - No pending request: stay in IDLE.
  - Any pending request: choose a winner, latch its address, data and operation, go to MEM_REQ.
- Pending request: `i_req`, or `d_read` | `d_write`.
- Winner selection:
  - If only one requester is pending, it wins.
  - If both are pending, round-robin: the requester not in `last_grant` wins.
  - `last_grant` updates on every grant. Its reset value is ICACHE, so the first tie goes to the dcache.
- dcache with both `d_read` and `d_write` high: treated as a write.
- Address and data rules:
  - Reads: `mem_address` = `{addr[31:4], 4'b0000}`.
  - Writes: `mem_address` = full `d_address`; `mem_write_data` = `d_write_data`.
  - Both are taken from latched registers and stay stable through MEM_REQ.
- MEM_REQ behaviour:
  - Exactly one of `mem_read_out` or `mem_write_out` is high.
  - On `mem_ready`: capture `mem_block_read_data` into a 128-bit register, clear both strobes, go to RESP.
  - On a write the captured block is don't-care; the ready pulse is still issued.
- Timeout:
  - A cycle counter, width `$clog2(TIMEOUT_CYCLES)`, runs in MEM_REQ.
  - If it reaches `TIMEOUT_CYCLES-1` without `mem_ready`: clear the strobes, set `timeout`=1, load the block register with 0, go to RESP. The requester is released with zero data.
- RESP: pulse `i_ready` or `d_ready` (granted side only) for one cycle, then go to IDLE.
- `mem_ready` seen in IDLE or RESP is ignored.
- Requester inputs are not re-sampled after the grant; changes during MEM_REQ have no effect.

## Timing

- Reset values: state IDLE, `last_grant` ICACHE, counter 0. All outputs are 0: `i_ready`, `d_ready`, `mem_read_out`, `mem_write_out`, `mem_address`, `mem_write_data`, `i_block_data`, `d_block_data`, `busy`, `timeout`.
- All outputs are registered.
- Request first seen high in IDLE at cycle N: strobe and address are valid from N+1.
- `mem_ready` at cycle M: strobes are low and the ready pulse plus data are valid at M+1; the arbiter is back in IDLE at M+2.
- Minimum transaction: 3 cycles (request, MEM_REQ with immediate `mem_ready`, RESP).
- The requester must drop its request on the edge that ends its ready cycle. The arbiter does not see the old request at M+2.
- Back-to-back: a request from the other side pending at M+2 is granted at M+2; no idle bubble beyond RESP.
- Reset asserted mid-transaction: all state and outputs go to reset values immediately (asynchronous); the in-flight memory operation is abandoned.

## Structure

- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, MEM_REQ, RESP}.
  - `grant_t` enum {ICACHE, DCACHE}.
  - Constant `BLOCK_BITS` = 128.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin. Inputs: two requests and `last_grant`. Outputs: winner and a valid flag. Used by IDLE.
- Top level holds the FSM, latch registers, timeout counter and block register.

## Test plan

- Single icache read: `i_req`=1 with `i_address`=0x0000_1234. Required: `mem_read_out`=1 and `mem_address`=0x0000_1230 from the next cycle. Memory returns block 0xA5…A5 with `mem_ready` 2 cycles later. Required: `i_ready` pulses once with that block; `d_ready` stays 0.
- dcache write: `d_write`=1, `d_address`=0x0000_0048, `d_write_data`=0xDEAD_BEEF_0000_0001. Required: `mem_write_out`=1 with the address unmasked and the data exact; `d_ready` pulses one cycle after `mem_ready`.
- Tie after reset: `i_req` and `d_read` high together. Required: dcache granted first; icache granted at the IDLE cycle following dcache's RESP (no extra gap); the next tie goes to the dcache again.
- Timeout with `TIMEOUT_CYCLES`=8 and `mem_ready` held 0. Required: strobes drop after 8 MEM_REQ cycles; `timeout`=1 and stays 1; the requester's ready pulses with data 0; the next request still proceeds normally.
- Reset mid-MEM_REQ: assert `reset` between clock edges. Required: all outputs 0 without waiting for an edge, `busy`=0, and after release the next tie goes to the dcache.
